axi_mst_wch_gen: RTL

Parametrised AXI3 master-side write-data generator with B/R ready shaping, for the crossbar bench.
- Snoops the AW handshake and queues {awid, awlen} in an outstanding-request FIFO of configurable depth.
- Plays out W bursts in AW order with LFSR payload, correct wid/wlast/wstrb, and AXI-compliant hold under backpressure.
- Drives bready/rready per a selectable policy and flags queue overflow.

---
 rtl/axi_mst_pkg.sv | 29 ++
 rtl/axi_ostd_fifo.sv | 55 +++++
 rtl/axi_mst_wch_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/axi_mst_pkg.sv
// Shared types and helpers for the AXI master bench generators: outstanding-entry type,
// ready-policy encoding and the 32-bit Galois LFSR (x^32+x^22+x^2+x+1).
package axi_mst_pkg;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      RDY_ONE  = 2'd0,
      RDY_RAND = 2'd1,
      RDY_ZERO = 2'd2
   } ready_mode_e;

   // Entry at the default AXI3 widths; generators with other widths use their own packing.
   typedef struct packed {
      logic [3:0] id;
      logic [3:0] len;
   } ostd_entry_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

   function automatic logic [31:0] lfsr_rotl(input logic [31:0] s, input int unsigned k);
      logic [63:0] d;
      d = {s, s} << (k % 32);
      return d[63:32];
   endfunction

endpackage

// File: rtl/axi_ostd_fifo.sv
// Generic synchronous FIFO with occupancy count; pushes while full are accepted only
// when a pop happens in the same cycle.
module axi_ostd_fifo
   import axi_mst_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] head,
   output logic [PTR_W:0]    count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
         else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/axi_mst_wch_gen.sv
// AXI3 master W-channel generator: snoops AW, replays W bursts in AW order with LFSR data,
// shapes bready/rready. Optional beat throttling via macro AXI_MST_WCH_GEN_THROTTLE_EN.
module axi_mst_wch_gen
   import axi_mst_pkg::*;
#(
   parameter int          AXI_ID_W        = 4,
   parameter int          AXI_DATA_W      = 32,
   parameter int          AXI_LEN_W       = 4,
   parameter int          MST_OSTDREQ_NUM = 4,
   parameter logic [31:0] LFSR_SEED       = 32'h1,
   parameter int          READY_MODE      = 0
) (
   input  logic                               aclk,
   input  logic                               aresetn,
   input  logic                               srst,
   input  logic                               in_awvalid,
   input  logic                               in_awready,
   input  logic [AXI_ID_W-1:0]                in_awid,
   input  logic [AXI_LEN_W-1:0]               in_awlen,
   output logic                               out_aw_full,
   output logic                               out_wvalid,
   input  logic                               in_wready,
   output logic                               out_wlast,
   output logic [AXI_ID_W-1:0]                out_wid,
   output logic [AXI_DATA_W-1:0]              out_wdata,
   output logic [AXI_DATA_W/8-1:0]            out_wstrb,
   output logic                               out_bready,
   output logic                               out_rready,
   output logic [$clog2(MST_OSTDREQ_NUM):0]   out_ostd_cnt,
   output logic                               out_err_ovf
);

   localparam int          CNT_W = $clog2(MST_OSTDREQ_NUM) + 1;
   localparam int          LANES = AXI_DATA_W / 32;
   localparam ready_mode_e RMODE = ready_mode_e'(READY_MODE);

   typedef struct packed {
      logic [AXI_ID_W-1:0]  id;
      logic [AXI_LEN_W-1:0] len;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_e;

   state_e               state, state_nxt;
   entry_t               push_entry, head;
   logic                 full, empty, push, pop, hs, last_beat, gap_req;
   logic [AXI_LEN_W-1:0] beat_cnt;
   logic [31:0]          lfsr, rnd;

   assign push       = in_awvalid & in_awready;
   assign push_entry = '{id: in_awid, len: in_awlen};

   axi_ostd_fifo #(
      .DATA_W ($bits(entry_t)),
      .DEPTH  (MST_OSTDREQ_NUM)
   ) u_fifo (
      .clk   (aclk),
      .rst_n (aresetn),
      .clr   (srst),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .head  (head),
      .count (out_ostd_cnt),
      .full  (full),
      .empty (empty)
   );

   assign out_aw_full = full;
   assign out_wvalid  = (state == S_BURST);
   assign last_beat   = (beat_cnt == head.len);
   assign out_wlast   = out_wvalid & last_beat;
   assign out_wid     = out_wvalid ? head.id : '0;
   assign out_wstrb   = {(AXI_DATA_W/8){out_wvalid}};
   assign hs          = out_wvalid & in_wready;
   assign pop         = hs & last_beat;

   // Data only moves on a handshake, so the hold rule falls out of the LFSR update.
   always_comb begin
      out_wdata = '0;
      for (int k = 0; k < LANES; k++) begin
         if (out_wvalid) out_wdata[32*k +: 32] = lfsr_rotl(lfsr, k);
      end
   end

`ifdef AXI_MST_WCH_GEN_THROTTLE_EN
   assign gap_req = rnd[0];
`else
   assign gap_req = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (!empty) state_nxt = S_BURST;
         S_BURST: if (hs) begin
            // Last beat of the only queued burst with nothing arriving: fall back to idle.
            if (last_beat && out_ostd_cnt == CNT_W'(1) && !push) state_nxt = S_IDLE;
            else if (gap_req)                                     state_nxt = S_GAP;
         end
         S_GAP:   state_nxt = S_BURST;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= S_IDLE;
         beat_cnt    <= '0;
         lfsr        <= LFSR_SEED;
         rnd         <= ~LFSR_SEED;
         out_err_ovf <= 1'b0;
         out_bready  <= 1'b0;
         out_rready  <= 1'b0;
      end else if (srst) begin
         state       <= S_IDLE;
         beat_cnt    <= '0;
         lfsr        <= LFSR_SEED;
         rnd         <= ~LFSR_SEED;
         out_err_ovf <= 1'b0;
         out_bready  <= 1'b0;
         out_rready  <= 1'b0;
      end else begin
         state <= state_nxt;
         rnd   <= lfsr_step(rnd);
         if (hs) begin
            lfsr     <= lfsr_step(lfsr);
            beat_cnt <= last_beat ? '0 : beat_cnt + AXI_LEN_W'(1);
         end
         if (push && full && !pop) out_err_ovf <= 1'b1;
         if (RMODE == RDY_RAND) begin
            out_bready <= rnd[5];
            out_rready <= rnd[17];
         end else if (RMODE == RDY_ZERO) begin
            out_bready <= 1'b0;
            out_rready <= 1'b0;
         end else begin
            out_bready <= 1'b1;
            out_rready <= 1'b1;
         end
      end
   end

endmodule
